data_mem_pipe: RTL
==================

// Module: data_mem_pipe
// PURPOSE
//  Parametrised data memory for the pipelined core's MEM stage. Successor to the single-port word RAM.
//  Adds: configurable width/depth/base, byte-lane write strobes, configurable read latency,
//  valid/ready request handshake, response FIFO with credit-based flow control, and address-error reporting.
//  Writes are posted (no response). Every accepted read returns exactly one in-order response.
// PARAMETERS
//  DATA_W    32  data word width in bits; must be a multiple of 8
//  ADDR_W    32  byte-address width
//  DEPTH     64  number of words; must be a power of 2
//  BASE_ADDR 0   byte address of word 0; must be aligned to DATA_W/8
//  RD_LAT    1   read-pipeline latency in cycles, 1..4
//  RSP_DEPTH 4   response FIFO entries, >=1; full throughput needs RSP_DEPTH >= RD_LAT+1
// PORTS
//  clk        in   1          clock; all state updates on rising edge
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   1          request present
//  req_ready  out  1          block can accept a request this cycle
//  req_we     in   1          1 = write, 0 = read
//  req_addr   in   ADDR_W     byte address
//  req_wdata  in   DATA_W     write data
//  req_be     in   DATA_W/8   byte-lane write enables; bit i gates bits [8i+7:8i]
//  rsp_valid  out  1          read response available
//  rsp_ready  in   1          consumer accepts the response
//  rsp_rdata  out  DATA_W     read data; 0 when rsp_err=1
//  rsp_err    out  1          read was misaligned or out of range
//  wr_err     out  1          sticky: a write was misaligned or out of range
// BEHAVIOUR
//  - Request handshake: accept when req_valid && req_ready. One request per cycle.
//  - Address index: idx = (req_addr - BASE_ADDR) >> log2(DATA_W/8).
//    - Error condition: the low log2(DATA_W/8) bits are non-zero, OR req_addr < BASE_ADDR, OR idx >= DEPTH.
//  - Credit counter `outst`: reads accepted minus responses popped.
//    - Range is 0..RSP_DEPTH.
//    - +1 on read accept; -1 on rsp_valid && rsp_ready; both in the same cycle leaves it unchanged.
//    - req_ready = !rst && (outst < RSP_DEPTH). This gates writes as well as reads.
//  - Write accepted at edge t: lanes with be=1 are updated at edge t; lanes with be=0 are untouched.
//    - be=0 is a legal no-op.
//    - An erroneous write leaves memory unchanged and sets wr_err=1 until rst.
//  - Read accepted at edge t: samples memory state after all writes accepted before t (write-first ordering).
//    - Read at t+1 to an address written at t returns the new data.
//    - Data passes an RD_LAT-stage registered pipeline, then enters a first-word-fall-through FIFO.
//    - With the FIFO empty, rsp_valid is high during cycle t+RD_LAT (accept edge = cycle t).
//    - An erroneous read still takes RD_LAT cycles and returns rdata=0, err=1.
//  - Response outputs are held stable while rsp_valid && !rsp_ready. Responses are delivered in accept order.
//  - The FIFO cannot overflow, because credits bound the reads in flight.
//  - Reset, including mid-operation:
//    - Clears the pipeline, FIFO, outst and wr_err.
//    - In-flight reads are discarded and produce no response.
//    - Memory contents are preserved.
//    - Outputs during and after reset: req_ready=0 while rst is high; rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_err=0.
//    - req_ready=1 in the first cycle after rst falls.
// TESTING
//  1 Write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> one response 0xDEADBEEF, err=0, RD_LAT cycles later.
//  2 Write 0x11223344 to 0x08; write 0xAABBCCDD to 0x08 with be=4'b0101; read 0x08 -> 0x11BB33DD.
//  3 Read 0x102 (misaligned) and read 0x100 (idx 64, DEPTH=64) -> two responses, rdata=0, err=1.
//    Write to 0x100 -> wr_err=1 and stays high.
//  4 rsp_ready=0, issue 6 back-to-back reads with RSP_DEPTH=4 -> req_ready drops after the 4th accept.
//    Raise rsp_ready -> exactly 6 in-order responses; no loss or duplication.
//  5 RD_LAT=3, rsp_ready=1, 16 back-to-back reads -> req_ready stays 1; one response per cycle from cycle 3.
//  6 Assert rst with 2 reads in flight -> no responses; outst=0; req_ready=1 the cycle after rst falls.
//    Contents written before reset read back unchanged.

Source files
------------

// File: rtl/data_mem_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_pipe : MEM-stage data memory with byte strobes, fixed-latency   |
// |                 read pipeline, FWFT response FIFO and credit gating      |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module data_mem_pipe #(
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 32,
  parameter int              DEPTH     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              RD_LAT    = 1,
  parameter int              RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                wr_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [ADDR_W-1:0] rel_addr;
  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  idx;
  logic              addr_err;
  logic              req_acc;
  logic              rd_acc;
  logic              wr_acc;
  logic              rsp_fire;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_word;
  logic [DATA_W-1:0] wr_merge;
  logic [DATA_W-1:0] rd_data;

  logic              push_vld;
  logic [DATA_W-1:0] push_data;
  logic              push_err;

  logic [DATA_W-1:0]    fifo_data_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fifo_err_q;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     outst_q, outst_d;
  logic                 wr_err_q, wr_err_d;

  assign rel_addr = req_addr - BASE_ADDR;
  assign word_idx = rel_addr >> OFF_W;
  assign idx      = word_idx[IDX_W-1:0];
  assign addr_err = ((req_addr & ADDR_W'(BYTES - 1)) != '0) ||
                    (req_addr < BASE_ADDR) ||
                    (word_idx >= ADDR_W'(DEPTH));

  // Credits cover both the pipeline and the FIFO, so the FIFO can never overflow.
  assign req_ready = !rst && (outst_q < CNT_W'(RSP_DEPTH));
  assign req_acc   = req_valid && req_ready;
  assign rd_acc    = req_acc && !req_we;
  assign wr_acc    = req_acc && req_we;

  assign mem_word = mem_q[idx];
  assign rd_data  = addr_err ? '0 : mem_word;

  always_comb begin
    wr_merge = mem_word;
    for (int b = 0; b < BYTES; b++) begin
      if (req_be[b]) wr_merge[8*b +: 8] = req_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !addr_err) mem_q[idx] <= wr_merge;
  end

  // The FIFO write is the last registered stage, so RD_LAT-1 stages precede it.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign push_vld  = rd_acc;
      assign push_data = rd_data;
      assign push_err  = addr_err;
    end else begin : g_latn
      logic              pv_q [RD_LAT-1];
      logic              pv_d [RD_LAT-1];
      logic [DATA_W-1:0] pd_q [RD_LAT-1];
      logic [DATA_W-1:0] pd_d [RD_LAT-1];
      logic              pe_q [RD_LAT-1];
      logic              pe_d [RD_LAT-1];

      always_comb begin
        pv_d[0] = rd_acc;
        pd_d[0] = rd_data;
        pe_d[0] = addr_err;
        for (int s = 1; s < RD_LAT - 1; s++) begin
          pv_d[s] = pv_q[s-1];
          pd_d[s] = pd_q[s-1];
          pe_d[s] = pe_q[s-1];
        end
      end

      always_ff @(posedge clk) begin
        for (int s = 0; s < RD_LAT - 1; s++) begin
          if (rst) begin
            pv_q[s] <= 1'b0;
            pd_q[s] <= '0;
            pe_q[s] <= 1'b0;
          end else begin
            pv_q[s] <= pv_d[s];
            pd_q[s] <= pd_d[s];
            pe_q[s] <= pe_d[s];
          end
        end
      end

      assign push_vld  = pv_q[RD_LAT-2];
      assign push_data = pd_q[RD_LAT-2];
      assign push_err  = pe_q[RD_LAT-2];
    end
  endgenerate

  assign rsp_valid = !rst && (cnt_q != '0);
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign rsp_err   = rsp_valid && fifo_err_q[rd_ptr_q];
  assign wr_err    = !rst && wr_err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    outst_d  = outst_q;
    wr_err_d = wr_err_q || (wr_acc && addr_err);
    if (push_vld) wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (rsp_fire) rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push_vld, rsp_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    case ({rd_acc, rsp_fire})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      outst_q  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      outst_q  <= outst_d;
      wr_err_q <= wr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_err_q[wr_ptr_q]  <= push_err;
    end
  end

endmodule
`default_nettype wire
